// File: rtl/dma_ctrl16_pkg.sv
// Shared definitions for the 16-bit block-copy DMA controller: FSM states,
// register offsets inside the I/O window and CTRL register bit positions.
package dma_ctrl16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_REL
  } state_t;

  localparam logic [1:0] DMA_SRC  = 2'd0;
  localparam logic [1:0] DMA_DST  = 2'd1;
  localparam logic [1:0] DMA_LEN  = 2'd2;
  localparam logic [1:0] DMA_CTRL = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_DONE_BIT  = 1;

endpackage

// File: rtl/dma_ctrl16_if.sv
// CPU register bus plus shared memory bus of the DMA controller; the master
// modport is the controller's view, the slave modport is the system's view.
interface dma_ctrl16_if;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_we;
  logic [15:0] reg_dout;
  logic        hold;
  logic        busy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [15:0] dma_dout;
  logic [15:0] dma_din;
  logic        dma_we;
  logic        done;

  modport master (
    input  cpu_addr, cpu_din, cpu_we, busy, dma_din,
    output reg_dout, hold, dma_active, dma_addr, dma_dout, dma_we, done
  );

  modport slave (
    output cpu_addr, cpu_din, cpu_we, busy, dma_din,
    input  reg_dout, hold, dma_active, dma_addr, dma_dout, dma_we, done
  );
endinterface

// File: rtl/dma16_regs.sv
// Programming registers of the DMA controller: window decode, SRC/DST/LEN
// storage, combinational read mux and the single-cycle start pulse.
module dma16_regs
  import dma_ctrl16_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h2100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic        cpu_we,
  input  logic        run,
  input  logic        done,
  output logic [15:0] src,
  output logic [15:0] dst,
  output logic [15:0] len,
  output logic [15:0] reg_dout,
  output logic        start
);

  logic [15:0] offset;
  logic        hit;
  logic        wr_ok;

  // Subtracting the base lets the window sit at any address, aligned or not.
  assign offset = cpu_addr - BASE_ADDR;
  assign hit    = (offset[15:2] == 14'd0);
  assign wr_ok  = cpu_we && hit && !run;
  assign start  = wr_ok && (offset[1:0] == DMA_CTRL) && cpu_din[CTRL_START_BIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      src <= 16'd0;
      dst <= 16'd0;
      len <= 16'd0;
    end else if (wr_ok) begin
      case (offset[1:0])
        DMA_SRC: src <= cpu_din;
        DMA_DST: dst <= cpu_din;
        DMA_LEN: len <= cpu_din;
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_dout = 16'd0;
    if (hit) begin
      case (offset[1:0])
        DMA_SRC: reg_dout = src;
        DMA_DST: reg_dout = dst;
        DMA_LEN: reg_dout = len;
        default: begin
          reg_dout[CTRL_RUN_BIT]  = run;
          reg_dout[CTRL_DONE_BIT] = done;
        end
      endcase
    end
  end

endmodule

// File: rtl/dma_ctrl16.sv
// Block-copy DMA controller: requests the bus with hold/busy, copies LEN words
// from SRC to DST one at a time, then releases the bus and raises sticky done.
module dma_ctrl16
  import dma_ctrl16_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h2100,
  parameter int          MEM_LAT   = 1
) (
  input  logic         clk,
  input  logic         reset,
  dma_ctrl16_if.master bus
);

  state_t      state, next_state;
  logic [15:0] src, dst, len;
  logic [15:0] sp, dp, cnt;
  logic [15:0] data_reg;
  logic [1:0]  lat_cnt;
  logic        lat_last;
  logic        run, done, start;

  dma16_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (bus.cpu_addr),
    .cpu_din  (bus.cpu_din),
    .cpu_we   (bus.cpu_we),
    .run      (run),
    .done     (done),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .reg_dout (bus.reg_dout),
    .start    (start)
  );

  assign lat_last     = (lat_cnt == 2'(MEM_LAT - 1));
  assign bus.dma_dout = data_reg;
  assign bus.done     = done;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Working copies advance during the copy; the programmed registers never do.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp       <= 16'd0;
      dp       <= 16'd0;
      cnt      <= 16'd0;
      data_reg <= 16'd0;
      lat_cnt  <= 2'd0;
      run      <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == 16'd0) begin
              done <= 1'b1;
            end else begin
              sp   <= src;
              dp   <= dst;
              cnt  <= len;
              done <= 1'b0;
              run  <= 1'b1;
            end
          end
        end
        ST_RD: lat_cnt <= 2'd0;
        ST_CAP: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_last) data_reg <= bus.dma_din;
        end
        ST_WR: begin
          sp  <= sp + 16'd1;
          dp  <= dp + 16'd1;
          cnt <= cnt - 16'd1;
        end
        ST_REL: begin
          if (!bus.busy) begin
            done <= 1'b1;
            run  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are decoded from the state alone so none of them follows busy.
  always_comb begin
    next_state     = state;
    bus.hold       = 1'b0;
    bus.dma_active = 1'b0;
    bus.dma_we     = 1'b0;
    bus.dma_addr   = 16'd0;
    case (state)
      ST_IDLE: if (start && len != 16'd0) next_state = ST_REQ;
      ST_REQ: begin
        bus.hold = 1'b1;
        if (bus.busy) next_state = ST_RD;
      end
      ST_RD: begin
        bus.hold       = 1'b1;
        bus.dma_active = 1'b1;
        bus.dma_addr   = sp;
        next_state     = ST_CAP;
      end
      ST_CAP: begin
        bus.hold       = 1'b1;
        bus.dma_active = 1'b1;
        bus.dma_addr   = sp;
        if (lat_last) next_state = ST_WR;
      end
      ST_WR: begin
        bus.hold       = 1'b1;
        bus.dma_active = 1'b1;
        bus.dma_we     = 1'b1;
        bus.dma_addr   = dp;
        next_state     = (cnt == 16'd1) ? ST_REL : ST_RD;
      end
      ST_REL: if (!bus.busy) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_ctrl16.sv
// Directed testbench for dma_ctrl16 with a 1-cycle synchronous RAM model and
// a CPU model that grants busy a programmable number of cycles after hold.
module tb_dma_ctrl16;

  localparam logic [15:0] BASE = 16'h2100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_ctrl16_if bus();

  dma_ctrl16 #(.BASE_ADDR(BASE), .MEM_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [0:65535];
  logic        tb_we;
  logic [15:0] tb_waddr, tb_wdata;
  logic [15:0] rd_q;

  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (bus.dma_we) mem[bus.dma_addr] <= bus.dma_dout;
    rd_q <= mem[bus.dma_addr];
  end
  assign bus.dma_din = rd_q;

  // CPU model: busy rises grant_delay+1 edges after hold, falls release_delay+1 edges after hold drops.
  int grant_delay, release_delay;
  int hcnt, rcnt;
  always @(posedge clk) begin
    if (reset) begin
      bus.busy <= 1'b0;
      hcnt     <= 0;
      rcnt     <= 0;
    end else if (bus.hold) begin
      rcnt <= 0;
      if (hcnt >= grant_delay) bus.busy <= 1'b1;
      else hcnt <= hcnt + 1;
    end else begin
      hcnt <= 0;
      if (bus.busy) begin
        if (rcnt >= release_delay) bus.busy <= 1'b0;
        else rcnt <= rcnt + 1;
      end
    end
  end

  int hold_cycles = 0, active_cycles = 0, we_count = 0, req_cycles = 0, viol = 0;
  logic [15:0] wr_addrs[$];
  always @(negedge clk) begin
    if (bus.hold) hold_cycles++;
    if (bus.dma_active) active_cycles++;
    if (bus.hold && !bus.dma_active) req_cycles++;
    if (bus.dma_active && !bus.busy) viol++;
    if (bus.dma_we) begin
      we_count++;
      wr_addrs.push_back(bus.dma_addr);
    end
  end

  int compared = 0, mismatched = 0;

  task automatic cpu_write(input logic [1:0] off, input logic [15:0] d);
    @(negedge clk);
    bus.cpu_addr = BASE + {14'd0, off};
    bus.cpu_din  = d;
    bus.cpu_we   = 1'b1;
    @(negedge clk);
    bus.cpu_we   = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] off, output logic [15:0] d);
    bus.cpu_addr = BASE + {14'd0, off};
    #1 d = bus.reg_dout;
  endtask

  task automatic mem_load(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ok = 1'b1;
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s_timeout: done=%b after %0d cycles, required 1", name, bus.done, budget);
    end
  endtask

  task automatic test_reset();
    logic [15:0] r;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++; if (bus.hold !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_hold: got %b want 0", bus.hold); end
    compared++; if (bus.dma_active !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_active: got %b want 0", bus.dma_active); end
    compared++; if (bus.dma_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we: got %b want 0", bus.dma_we); end
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
    compared++; if (bus.dma_addr !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_addr: got %h want 0000", bus.dma_addr); end
    compared++; if (bus.dma_dout !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_dout: got %h want 0000", bus.dma_dout); end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cpu_read(2'(i), r);
      compared++;
      if (r !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_reg%0d: got %h want 0000", i, r); end
    end
    bus.cpu_addr = 16'h2104;
    #1;
    compared++; if (bus.reg_dout !== 16'h0000) begin mismatched++; $display("[TB] FAIL outside_window: got %h want 0000", bus.reg_dout); end
  endtask

  task automatic test_len_zero();
    int h0;
    logic [15:0] r;
    cpu_write(2'd2, 16'd0);
    h0 = hold_cycles;
    cpu_write(2'd3, 16'd1);
    compared++; if (bus.done !== 1'b1) begin mismatched++; $display("[TB] FAIL len0_done: got %b want 1", bus.done); end
    repeat (4) @(negedge clk);
    compared++; if (hold_cycles - h0 != 0) begin mismatched++; $display("[TB] FAIL len0_hold: got %0d hold cycles want 0", hold_cycles - h0); end
    cpu_read(2'd3, r);
    compared++; if (r !== 16'h0002) begin mismatched++; $display("[TB] FAIL len0_ctrl: got %h want 0002", r); end
  endtask

  task automatic test_basic();
    int h0, a0, w0, q0;
    logic [15:0] r;
    for (int i = 0; i < 4; i++) mem_load(16'h0010 + 16'(i), 16'h00A0 + 16'(i));
    cpu_write(2'd0, 16'h0010);
    cpu_write(2'd1, 16'h0100);
    cpu_write(2'd2, 16'd4);
    h0 = hold_cycles; a0 = active_cycles; w0 = we_count; q0 = wr_addrs.size();
    cpu_write(2'd3, 16'd1);
    compared++; if (bus.hold !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_hold_rise: got %b want 1", bus.hold); end
    wait_done(100, "basic");
    compared++; if (we_count - w0 != 4) begin mismatched++; $display("[TB] FAIL basic_we_pulses: got %0d want 4", we_count - w0); end
    // REQ lasts 2 cycles with a one-cycle grant, then 3 cycles per word
    compared++; if (hold_cycles - h0 != 14) begin mismatched++; $display("[TB] FAIL basic_hold_len: got %0d want 14", hold_cycles - h0); end
    compared++; if (active_cycles - a0 != 12) begin mismatched++; $display("[TB] FAIL basic_active_len: got %0d want 12", active_cycles - a0); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (mem[16'h0100 + 16'(i)] !== 16'h00A0 + 16'(i)) begin
        mismatched++; $display("[TB] FAIL basic_data%0d: got %h want %h", i, mem[16'h0100 + 16'(i)], 16'h00A0 + 16'(i));
      end
      compared++;
      if (wr_addrs.size() > q0 + i && wr_addrs[q0 + i] !== 16'h0100 + 16'(i)) begin
        mismatched++; $display("[TB] FAIL basic_waddr%0d: got %h want %h", i, wr_addrs[q0 + i], 16'h0100 + 16'(i));
      end
    end
    cpu_read(2'd3, r);
    compared++; if (r !== 16'h0002) begin mismatched++; $display("[TB] FAIL basic_ctrl: got %h want 0002", r); end
    cpu_read(2'd0, r);
    compared++; if (r !== 16'h0010) begin mismatched++; $display("[TB] FAIL basic_src_kept: got %h want 0010", r); end
    cpu_read(2'd2, r);
    compared++; if (r !== 16'h0004) begin mismatched++; $display("[TB] FAIL basic_len_kept: got %h want 0004", r); end
  endtask

  task automatic test_wrap();
    int q0;
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 16'hFFFE + 16'(i);
      mem_load(a, 16'h00B0 + 16'(i));
    end
    cpu_write(2'd0, 16'hFFFE);
    cpu_write(2'd1, 16'h0200);
    cpu_write(2'd2, 16'd4);
    q0 = wr_addrs.size();
    cpu_write(2'd3, 16'd1);
    wait_done(100, "wrap");
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (mem[16'h0200 + 16'(i)] !== 16'h00B0 + 16'(i)) begin
        mismatched++; $display("[TB] FAIL wrap_data%0d: got %h want %h", i, mem[16'h0200 + 16'(i)], 16'h00B0 + 16'(i));
      end
    end
    compared++;
    if (wr_addrs.size() != q0 + 4) begin mismatched++; $display("[TB] FAIL wrap_writes: got %0d want 4", wr_addrs.size() - q0); end
  endtask

  task automatic test_grant_delay();
    int r0, v0, n, early;
    grant_delay = 9;
    release_delay = 5;
    cpu_write(2'd0, 16'h0010);
    cpu_write(2'd1, 16'h0500);
    cpu_write(2'd2, 16'd2);
    r0 = req_cycles; v0 = viol;
    cpu_write(2'd3, 16'd1);
    n = 0;
    while (bus.hold === 1'b1 && n < 100) begin @(negedge clk); n++; end
    compared++; if (req_cycles - r0 != 11) begin mismatched++; $display("[TB] FAIL grant_req_len: got %0d want 11", req_cycles - r0); end
    compared++; if (viol != v0) begin mismatched++; $display("[TB] FAIL grant_active_no_busy: got %0d cycles want 0", viol - v0); end
    early = 0; n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      if (bus.done === 1'b1) early++;
      @(negedge clk); n++;
    end
    compared++; if (early != 0 || n != 6) begin mismatched++; $display("[TB] FAIL grant_release: done early %0d, busy cycles %0d, want 0 and 6", early, n); end
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL grant_done_edge: got %b want 0", bus.done); end
    @(negedge clk);
    compared++; if (bus.done !== 1'b1) begin mismatched++; $display("[TB] FAIL grant_done: got %b want 1", bus.done); end
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (mem[16'h0500 + 16'(i)] !== 16'h00A0 + 16'(i)) begin
        mismatched++; $display("[TB] FAIL grant_data%0d: got %h want %h", i, mem[16'h0500 + 16'(i)], 16'h00A0 + 16'(i));
      end
    end
    grant_delay = 0;
    release_delay = 0;
  endtask

  task automatic test_busy_lockout();
    int w0, h0;
    logic [15:0] r;
    cpu_write(2'd0, 16'h0010);
    cpu_write(2'd1, 16'h0300);
    cpu_write(2'd2, 16'd4);
    w0 = we_count; h0 = hold_cycles;
    cpu_write(2'd3, 16'd1);
    cpu_write(2'd1, 16'h1234);
    cpu_write(2'd2, 16'd1);
    cpu_write(2'd3, 16'd1);
    wait_done(100, "lockout");
    repeat (5) @(negedge clk);
    cpu_read(2'd1, r);
    compared++; if (r !== 16'h0300) begin mismatched++; $display("[TB] FAIL lockout_dst: got %h want 0300", r); end
    cpu_read(2'd2, r);
    compared++; if (r !== 16'h0004) begin mismatched++; $display("[TB] FAIL lockout_len: got %h want 0004", r); end
    compared++; if (we_count - w0 != 4) begin mismatched++; $display("[TB] FAIL lockout_we: got %0d want 4", we_count - w0); end
    compared++; if (hold_cycles - h0 != 14) begin mismatched++; $display("[TB] FAIL lockout_hold: got %0d want 14", hold_cycles - h0); end
    compared++; if (mem[16'h0303] !== 16'h00A3) begin mismatched++; $display("[TB] FAIL lockout_data: got %h want 00a3", mem[16'h0303]); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      mem_load(16'h0020 + 16'(i), 16'h00C0 + 16'(i));
      mem_load(16'h0400 + 16'(i), 16'hDEAD);
    end
    cpu_write(2'd0, 16'h0020);
    cpu_write(2'd1, 16'h0400);
    cpu_write(2'd2, 16'd8);
    cpu_write(2'd3, 16'd1);
    n = 0;
    while (!(bus.dma_we === 1'b1 && bus.dma_addr === 16'h0402) && n < 200) begin @(negedge clk); n++; end
    compared++; if (n >= 200) begin mismatched++; $display("[TB] FAIL rstmid_reach_wr2: not reached in %0d cycles", n); end
    reset = 1'b1;
    @(negedge clk);
    compared++; if (bus.hold !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_hold: got %b want 0", bus.hold); end
    compared++; if (bus.dma_we !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_we: got %b want 0", bus.dma_we); end
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_done: got %b want 0", bus.done); end
    compared++; if (bus.dma_active !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_active: got %b want 0", bus.dma_active); end
    cpu_read(2'd0, r);
    compared++; if (r !== 16'h0000) begin mismatched++; $display("[TB] FAIL rstmid_src: got %h want 0000", r); end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (mem[16'h0400 + 16'(i)] !== ((i < 3) ? 16'h00C0 + 16'(i) : 16'hDEAD)) begin
        mismatched++; $display("[TB] FAIL rstmid_word%0d: got %h want %h", i, mem[16'h0400 + 16'(i)], (i < 3) ? 16'h00C0 + 16'(i) : 16'hDEAD);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_addr = 16'h0000;
    bus.cpu_din = 16'h0000;
    bus.cpu_we = 1'b0;
    tb_we = 1'b0;
    tb_waddr = 16'h0000;
    tb_wdata = 16'h0000;
    grant_delay = 0;
    release_delay = 0;
    test_reset();
    test_len_zero();
    test_basic();
    test_wrap();
    test_grant_delay();
    test_busy_lockout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
